// File: rtl/noise_pkg.sv
// Shared constants for the noise channel: frame-step selection, shift divisor table
// and the shift-period helper used when the shift timer reloads.
package noise_pkg;

    localparam int FRAME_DIV_DEFAULT = 8192;
    localparam int SHIFT_W           = 20;

    // Slot [r] holds the base divisor for divisor code r.
    localparam logic [7:0][6:0] DIV_TABLE = {7'd112, 7'd96, 7'd80, 7'd64,
                                             7'd48,  7'd32, 7'd16, 7'd8};

    // Bit n set means frame step n clocks the length counter.
    localparam logic [7:0] LEN_STEP_MASK  = 8'b0101_0101;
    localparam logic [2:0] ENV_STEP       = 3'd7;
    localparam logic [3:0] SHIFT_MUTE_MIN = 4'd14;

    // Larger shifts overflow the 20-bit timer; those settings are muted anyway.
    function automatic logic [SHIFT_W-1:0] shift_period(input logic [7:0] poly);
        logic [SHIFT_W-1:0] base;
        base = {{(SHIFT_W-7){1'b0}}, DIV_TABLE[poly[2:0]]};
        return base << poly[7:4];
    endfunction

endpackage

// File: rtl/vol_envelope.sv
// Volume envelope: direction and period are captured at load, the volume steps once
// per expiry of the envelope timer and stops for good at 0 or 15 until the next load.
module vol_envelope
    import noise_pkg::*;
(
    input  logic       I_SHIFT_CLOCK,
    input  logic       I_RESET,
    input  logic       load,
    input  logic       env_clk,
    input  logic [7:0] I_ENV_REG,
    output logic [3:0] volume
);

    logic [3:0] vol_reg,    vol_next;
    logic [2:0] timer_reg,  timer_next;
    logic [2:0] period_reg, period_next;
    logic       dir_reg,    dir_next;
    logic       active_reg, active_next;

    always_comb begin
        vol_next    = vol_reg;
        timer_next  = timer_reg;
        period_next = period_reg;
        dir_next    = dir_reg;
        active_next = active_reg;
        if (load) begin
            vol_next    = I_ENV_REG[7:4];
            dir_next    = I_ENV_REG[3];
            period_next = I_ENV_REG[2:0];
            timer_next  = I_ENV_REG[2:0];
            active_next = |I_ENV_REG[2:0];
        end else if (env_clk && active_reg) begin
            if (timer_reg <= 3'd1) begin
                timer_next = period_reg;
                if (dir_reg && vol_reg != 4'hF) begin
                    vol_next = vol_reg + 4'd1;
                end else if (!dir_reg && vol_reg != 4'h0) begin
                    vol_next = vol_reg - 4'd1;
                end else begin
                    active_next = 1'b0;
                end
            end else begin
                timer_next = timer_reg - 3'd1;
            end
        end
    end

    always_ff @(posedge I_SHIFT_CLOCK) begin
        if (I_RESET) begin
            vol_reg    <= '0;
            timer_reg  <= '0;
            period_reg <= '0;
            dir_reg    <= 1'b0;
            active_reg <= 1'b0;
        end else begin
            vol_reg    <= vol_next;
            timer_reg  <= timer_next;
            period_reg <= period_next;
            dir_reg    <= dir_next;
            active_reg <= active_next;
        end
    end

    assign volume = vol_reg;

endmodule

// File: rtl/noise_channel_sequencer.sv
// Noise channel control: frame sequencer, shift-rate timer, length counter and
// channel enable; the volume envelope lives in vol_envelope.
module noise_channel_sequencer
    import noise_pkg::*;
#(
    parameter int FRAME_DIV = FRAME_DIV_DEFAULT
) (
    input  logic       I_SHIFT_CLOCK,
    input  logic       I_RESET,
    input  logic [7:0] I_ENV_REG,
    input  logic [7:0] I_POLY_REG,
    input  logic [5:0] I_LENGTH_LOAD,
    input  logic       I_LENGTH_WR,
    input  logic       I_LENGTH_EN,
    input  logic       I_TRIGGER,
    output logic       O_SHIFT_TICK,
    output logic       O_LFSR_RESET,
    output logic       O_BIT_WIDTH,
    output logic [3:0] O_VOLUME,
    output logic       O_WAVEFORM_EN
);

    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic [DIV_W-1:0]   div_cnt_reg, div_cnt_next;
    logic [2:0]         step_reg,    step_next;
    logic [SHIFT_W-1:0] shift_cnt_reg, shift_cnt_next;
    logic [6:0]         len_reg,     len_next;
    logic               wave_reg,    wave_next;
    logic               tick_reg,    tick_next;
    logic               lfsr_reg;
    logic               width_reg;

    logic               frame_pulse;
    logic               len_clk;
    logic               env_clk;
    logic               dac_on;
    logic               shift_fire;
    logic [SHIFT_W-1:0] reload_period;

    // The clock a pulse produces is chosen by the step value before it advances.
    assign frame_pulse   = (div_cnt_reg == DIV_W'(FRAME_DIV - 1));
    assign len_clk       = frame_pulse && LEN_STEP_MASK[step_reg];
    assign env_clk       = frame_pulse && (step_reg == ENV_STEP);
    assign dac_on        = |I_ENV_REG[7:3];
    assign reload_period = shift_period(I_POLY_REG);

    always_comb begin
        div_cnt_next = frame_pulse ? '0 : div_cnt_reg + DIV_W'(1);
        step_next    = frame_pulse ? step_reg + 3'd1 : step_reg;
    end

    always_comb begin
        shift_cnt_next = shift_cnt_reg;
        len_next       = len_reg;
        wave_next      = wave_reg;
        shift_fire     = 1'b0;
        if (I_TRIGGER) begin
            wave_next      = dac_on;
            shift_cnt_next = reload_period;
            if (len_reg == 7'd0) begin
                len_next = 7'd64;
            end
        end else begin
            if (shift_cnt_reg <= SHIFT_W'(1)) begin
                shift_fire     = 1'b1;
                shift_cnt_next = reload_period;
            end else begin
                shift_cnt_next = shift_cnt_reg - SHIFT_W'(1);
            end
            if (len_clk && I_LENGTH_EN && len_reg != 7'd0 && !I_LENGTH_WR) begin
                len_next = len_reg - 7'd1;
                if (len_reg == 7'd1) begin
                    wave_next = 1'b0;
                end
            end
        end
        if (I_LENGTH_WR) begin
            len_next = 7'd64 - {1'b0, I_LENGTH_LOAD};
        end
        if (!dac_on) begin
            wave_next = 1'b0;
        end
        tick_next = shift_fire && (I_POLY_REG[7:4] < SHIFT_MUTE_MIN) && wave_next;
    end

    always_ff @(posedge I_SHIFT_CLOCK) begin
        if (I_RESET) begin
            div_cnt_reg   <= '0;
            step_reg      <= '0;
            shift_cnt_reg <= '0;
            len_reg       <= '0;
            wave_reg      <= 1'b0;
            tick_reg      <= 1'b0;
            lfsr_reg      <= 1'b0;
            width_reg     <= 1'b0;
        end else begin
            div_cnt_reg   <= div_cnt_next;
            step_reg      <= step_next;
            shift_cnt_reg <= shift_cnt_next;
            len_reg       <= len_next;
            wave_reg      <= wave_next;
            tick_reg      <= tick_next;
            lfsr_reg      <= I_TRIGGER;
            width_reg     <= I_POLY_REG[3];
        end
    end

    vol_envelope u_envelope (
        .I_SHIFT_CLOCK (I_SHIFT_CLOCK),
        .I_RESET       (I_RESET),
        .load          (I_TRIGGER),
        .env_clk       (env_clk),
        .I_ENV_REG     (I_ENV_REG),
        .volume        (O_VOLUME)
    );

    assign O_SHIFT_TICK  = tick_reg;
    assign O_LFSR_RESET  = lfsr_reg;
    assign O_BIT_WIDTH   = width_reg;
    assign O_WAVEFORM_EN = wave_reg;

endmodule

// File: tb/tb_noise_channel_sequencer.sv
// Directed and randomized checks of the noise channel sequencer against a
// cycle-count based reference model.
module tb_noise_channel_sequencer;

    localparam int F = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] env = 8'h00;
    logic [7:0] poly = 8'h00;
    logic [5:0] lload = 6'd0;
    logic       lwr = 1'b0;
    logic       len_en = 1'b0;
    logic       trig = 1'b0;

    logic       o_tick, o_lfsr, o_bw, o_en;
    logic [3:0] o_vol;

    int tests = 0;
    int fails = 0;

    noise_channel_sequencer #(.FRAME_DIV(F)) dut (
        .I_SHIFT_CLOCK (clk),
        .I_RESET       (rst),
        .I_ENV_REG     (env),
        .I_POLY_REG    (poly),
        .I_LENGTH_LOAD (lload),
        .I_LENGTH_WR   (lwr),
        .I_LENGTH_EN   (len_en),
        .I_TRIGGER     (trig),
        .O_SHIFT_TICK  (o_tick),
        .O_LFSR_RESET  (o_lfsr),
        .O_BIT_WIDTH   (o_bw),
        .O_VOLUME      (o_vol),
        .O_WAVEFORM_EN (o_en)
    );

    always #5 clk = ~clk;

    // Reference model: time is the count k of clock edges since reset released.
    int  k, len, vol, e_per, e_cnt, tick_due;
    bit  m_en, e_dir, e_act, m_tick, m_lfsr, m_bw;

    function automatic int period_of(input logic [7:0] p);
        int divs [8] = '{8, 16, 32, 48, 64, 80, 96, 112};
        int v;
        v = (divs[p[2:0]] << p[7:4]) & 32'h000F_FFFF;
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_edge();
        int  m, step;
        bit  len_clk, env_clk, dac, fire;
        if (rst) begin
            k = 0; len = 0; m_en = 0; vol = 0; e_per = 0; e_cnt = 0;
            e_dir = 0; e_act = 0; tick_due = 1; m_tick = 0; m_lfsr = 0; m_bw = 0;
            return;
        end
        k++;
        m       = k - 1;
        step    = (m / F) % 8;
        len_clk = (m % F == F - 1) && (step % 2 == 0);
        env_clk = (m % F == F - 1) && (step == 7);
        dac     = (env[7:3] != 0);
        fire    = 0;
        if (trig) begin
            m_en = dac;
            if (len == 0) len = 64;
            tick_due = k + period_of(poly);
            vol = env[7:4]; e_dir = env[3]; e_per = int'(env[2:0]);
            e_cnt = e_per; e_act = (e_per != 0);
        end else begin
            if (k == tick_due) begin
                fire = 1;
                tick_due = k + period_of(poly);
            end
            if (len_clk && len_en && len > 0 && !lwr) begin
                len--;
                if (len == 0) m_en = 0;
            end
            if (env_clk && e_act) begin
                e_cnt--;
                if (e_cnt == 0) begin
                    e_cnt = e_per;
                    if (e_dir && vol < 15) vol++;
                    else if (!e_dir && vol > 0) vol--;
                    else e_act = 0;
                end
            end
        end
        if (lwr) len = 64 - int'(lload);
        if (!dac) m_en = 0;
        m_tick = fire && (poly[7:4] < 14) && m_en;
        m_lfsr = trig;
        m_bw   = poly[3];
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s at k=%0d: got %0h expected %0h", tag, k, got, exp);
        end
    endtask

    // One clock: DUT and model both take the edge, outputs compared at the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("tick", {31'd0, o_tick}, {31'd0, m_tick});
        check("lfsr", {31'd0, o_lfsr}, {31'd0, m_lfsr});
        check("bitw", {31'd0, o_bw},   {31'd0, m_bw});
        check("vol",  {28'd0, o_vol},  vol);
        check("en",   {31'd0, o_en},   {31'd0, m_en});
    endtask

    task automatic run_count(input int n, output int ticks);
        ticks = 0;
        for (int i = 0; i < n; i++) begin
            cyc();
            if (o_tick) ticks++;
        end
    endtask

    task automatic pulse_trigger();
        trig = 1'b1;
        cyc();
        trig = 1'b0;
    endtask

    initial begin
        int  ticks;
        bit  found;

        // Reset state
        cyc();
        cyc();
        check("rst_en",  {31'd0, o_en},  32'd0);
        check("rst_vol", {28'd0, o_vol}, 32'd0);
        rst = 1'b0;
        $display("[TB] reset released");

        // Basic tone: full volume, period 8
        env = 8'hF0; poly = 8'h00;
        pulse_trigger();
        check("trig_en",   {31'd0, o_en},   32'd1);
        check("trig_vol",  {28'd0, o_vol},  32'd15);
        check("trig_lfsr", {31'd0, o_lfsr}, 32'd1);
        cyc();
        check("lfsr_once", {31'd0, o_lfsr}, 32'd0);
        run_count(63, ticks);
        $display("[TB] POLY=00 ticks in 64 cycles: %0d", ticks);
        check("tick_p8", ticks, 32'd8);

        // Period 256 and muted shift
        poly = 8'h32;
        pulse_trigger();
        run_count(512, ticks);
        $display("[TB] POLY=32 ticks in 512 cycles: %0d", ticks);
        check("tick_p256", ticks, 32'd2);
        poly = 8'hE0;
        pulse_trigger();
        run_count(300, ticks);
        $display("[TB] POLY=E0 ticks in 300 cycles: %0d", ticks);
        check("tick_mute", ticks, 32'd0);

        // Length expiry after two length clocks
        poly = 8'h00; lload = 6'd62; lwr = 1'b1;
        cyc();
        lwr = 1'b0; len_en = 1'b1;
        pulse_trigger();
        run_count(5 * F, ticks);
        check("len_off", {31'd0, o_en}, 32'd0);
        run_count(64, ticks);
        $display("[TB] length expiry: en=%0b ticks after=%0d", o_en, ticks);
        check("len_noticks", ticks, 32'd0);

        // Envelope ramp up with period 1
        len_en = 1'b0; env = 8'h09;
        pulse_trigger();
        check("env_start", {28'd0, o_vol}, 32'd0);
        for (int i = 0; i < 18 * 8 * F; i++) cyc();
        $display("[TB] envelope ramp final volume %0d", o_vol);
        check("env_sat", {28'd0, o_vol}, 32'd15);

        // Trigger coincident with a step-0 length clock while counter = 1
        env = 8'hF0; lload = 6'd63; lwr = 1'b1;
        cyc();
        lwr = 1'b0;
        pulse_trigger();
        found = 0;
        for (int i = 0; i < 20 * F && !found; i++) begin
            if ((k % F) == F - 1 && ((k / F) % 8) == 0) found = 1;
            else cyc();
        end
        check("find_step0", {31'd0, found}, 32'd1);
        len_en = 1'b1;
        pulse_trigger();
        $display("[TB] trigger on step-0 clock: en=%0b", o_en);
        check("trig_wins_en", {31'd0, o_en}, 32'd1);
        for (int i = 0; i < 3 * F; i++) cyc();
        check("trig_wins_later", {31'd0, o_en}, 32'd0);

        // DAC off forces the channel off; trigger cannot enable it
        len_en = 1'b0;
        pulse_trigger();
        env = 8'h07;
        cyc();
        check("dac_off", {31'd0, o_en}, 32'd0);
        pulse_trigger();
        check("dac_off_trig", {31'd0, o_en}, 32'd0);

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                env = 8'($urandom_range(0, 255));
                poly = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
                if ($urandom_range(0, 7) == 0) poly[7:4] = 4'($urandom_range(14, 15));
            end
            trig   = ($urandom_range(0, 99) == 0);
            lwr    = ($urandom_range(0, 149) == 0);
            lload  = 6'($urandom_range(40, 63));
            len_en = ($urandom_range(0, 3) != 0);
            cyc();
            trig = 1'b0; lwr = 1'b0;
        end
        $display("[TB] random phase done at k=%0d", k);

        // Reset mid-tone, with strobes in the same cycle
        env = 8'hF0; poly = 8'h08;
        pulse_trigger();
        for (int i = 0; i < 20; i++) cyc();
        rst = 1'b1; trig = 1'b1; lwr = 1'b1;
        cyc();
        rst = 1'b0; trig = 1'b0; lwr = 1'b0;
        $display("[TB] mid-tone reset: en=%0b vol=%0d tick=%0b bw=%0b", o_en, o_vol, o_tick, o_bw);
        check("mr_en",   {31'd0, o_en},   32'd0);
        check("mr_vol",  {28'd0, o_vol},  32'd0);
        check("mr_tick", {31'd0, o_tick}, 32'd0);
        check("mr_lfsr", {31'd0, o_lfsr}, 32'd0);
        check("mr_bw",   {31'd0, o_bw},   32'd0);
        len_en = 1'b1;
        pulse_trigger();
        for (int i = 0; i < 9 * 8 * F; i++) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/noise_channel_sequencer.md
NOISE_CHANNEL_SEQUENCER -- requirements
Module: noise_channel_sequencer

Interface
REQ-001 SHALL have parameter FRAME_DIV, default 8192, meaning I_SHIFT_CLOCK cycles per frame-sequencer step (512 Hz at 4.194304 MHz).
REQ-002 I_SHIFT_CLOCK  in  1  block clock.
REQ-003 I_RESET  in  1  reset: synchronous, active-high.
REQ-004 I_ENV_REG  in  8  envelope: [7:4] initial volume, [3] direction (1=up), [2:0] envelope period.
REQ-005 I_POLY_REG  in  8  polynomial: [7:4] shift s, [3] width mode (1=7-bit), [2:0] divisor code r.
REQ-006 I_LENGTH_LOAD  in  6  length value L.
REQ-007 I_LENGTH_WR  in  1  one-cycle strobe; reload length counter from I_LENGTH_LOAD.
REQ-008 I_LENGTH_EN  in  1  length counter enable.
REQ-009 I_TRIGGER  in  1  one-cycle channel restart strobe.
REQ-010 O_SHIFT_TICK  out  1  one-cycle shift enable for the downstream LFSR stage.
REQ-011 O_LFSR_RESET  out  1  one-cycle LFSR reload request.
REQ-012 O_BIT_WIDTH  out  1  registered copy of I_POLY_REG[3].
REQ-013 O_VOLUME  out  4  current envelope volume.
REQ-014 O_WAVEFORM_EN  out  1  channel active.

Function
REQ-015 Frame divider SHALL pulse every FRAME_DIV cycles; each pulse advances a 3-bit step counter 0..7, wrapping 7->0.
REQ-016 Length clock SHALL fire on steps 0,2,4,6; envelope clock SHALL fire on step 7.
REQ-017 Shift period SHALL be DIV[r] << s cycles, DIV = {8,16,32,48,64,80,96,112}; 20-bit timer.
REQ-018 Timer SHALL count down, emit O_SHIFT_TICK on the cycle it reaches zero, then reload from the current I_POLY_REG.
REQ-019 s = 14 or 15 SHALL suppress O_SHIFT_TICK; the timer keeps running.
REQ-020 O_SHIFT_TICK SHALL be 0 while O_WAVEFORM_EN = 0.
REQ-021 I_LENGTH_WR SHALL set the length counter to 64 - L (7-bit, range 1..64) in any state.
REQ-022 Length clock with I_LENGTH_EN = 1 and counter > 0 SHALL decrement the counter; reaching 0 SHALL clear O_WAVEFORM_EN on the next cycle.
REQ-023 Envelope: a nonzero period loads the envelope timer; at each envelope clock the timer decrements; at zero it reloads and volume steps by +/-1.
REQ-024 Volume SHALL saturate at 15 (up) and at 0 (down); once saturated, stepping SHALL stop until the next trigger.
REQ-025 Envelope period 0 SHALL freeze volume.
REQ-026 DAC off (I_ENV_REG[7:3] = 0) SHALL force O_WAVEFORM_EN = 0 within one cycle; a trigger SHALL NOT enable the channel while DAC is off.
REQ-027 Trigger effects, visible next cycle: O_WAVEFORM_EN = 1 (DAC on); length counter 0 -> 64; volume = I_ENV_REG[7:4]; envelope timer and stepping reloaded; shift timer = full period; O_LFSR_RESET pulses once.
REQ-028 Trigger coincident with a length or envelope clock: trigger SHALL win, and that clock SHALL NOT also act.
REQ-029 I_LENGTH_WR coincident with a length clock: the write SHALL win.
REQ-030 Frame divider and step counter SHALL be unaffected by a trigger.

Reset
REQ-031 Reset SHALL clear: O_SHIFT_TICK, O_LFSR_RESET, O_BIT_WIDTH, O_WAVEFORM_EN, O_VOLUME, the step counter, the frame divider, the envelope timer and the shift timer; the length counter SHALL reset to 0.
REQ-032 Reset mid-operation SHALL take priority over all strobes in the same cycle.

Structure
REQ-033 Shared package noise_pkg SHALL hold the DIV table, the FRAME_DIV default, and the step-select constants.
REQ-034 Envelope logic SHALL be sub-module vol_envelope (inputs: clock, reset, load, env clock, I_ENV_REG; output: volume).

Verification
REQ-035 FRAME_DIV=16, ENV=0xF0, POLY=0x00, trigger -> O_WAVEFORM_EN=1, O_VOLUME=15, O_LFSR_RESET one pulse, O_SHIFT_TICK every 8 cycles.
REQ-036 POLY=0x32 (r=2, s=3) -> tick period 256 cycles; POLY=0xE0 -> no ticks.
REQ-037 L=62, LENGTH_EN=1, trigger -> channel disabled after the 2nd length clock; ticks stop.
REQ-038 ENV=0x09 (vol 0, up, period 1), trigger -> volume 1,2,...,15 on successive step-7 pulses, then holds at 15.
REQ-039 Trigger on the same cycle as a step-0 length clock with counter = 1 -> counter = 1 (trigger wins), channel stays enabled.
REQ-040 I_RESET asserted mid-tone -> all outputs 0 next cycle; frame step restarts at 0.
